// File: rtl/switch_frame_fetch_pkg.sv
// Shared definitions for the frame fetch block: descriptor layout, FSM encodings, skid entry format.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package switch_frame_fetch_pkg;

   // Default width of the frame length field, in bytes
   localparam int DEFAULT_LEN_W = 11;

   // Descriptor layout: [19:16] tag, [15:12] one-hot source port, [11] reserved, [10:0] length
   localparam int DESC_W       = 20;
   localparam int DESC_TAG_LSB = 16;
   localparam int DESC_SRC_LSB = 12;
   localparam int DESC_LEN_LSB = 0;
   localparam int DESC_LEN_W   = 11;
   localparam int TAG_W        = 4;
   localparam int SRC_W        = 4;

   // Frame byte and skid entry {sof, eof, data}
   localparam int BYTE_W     = 8;
   localparam int SKID_ENT_W = BYTE_W + 2;

   // One-hot fetch FSM states
   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_LATCH = 4'b0010,
      ST_DATA  = 4'b0100,
      ST_DRAIN = 4'b1000
   } fetch_state_t;

   typedef struct packed {
      logic              sof;
      logic              eof;
      logic [BYTE_W-1:0] dat;
   } skid_ent_t;

endpackage

// File: rtl/switch_frame_fetch_skid_buf.sv
// Small skid buffer of {sof, eof, data} entries; entry 0 is always the registered head.
// Latency: a pushed entry is visible at the head one cycle later when the buffer was empty.
// Backpressure: caller must never push into a full buffer (occupancy is tracked upstream).
module frame_skid_buf
   import switch_frame_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk_sys,
   input  logic                         rstn_sys,
   input  logic                         i_push,
   input  logic [SKID_ENT_W-1:0]        i_dat,
   input  logic                         i_pop,
   output logic [SKID_ENT_W-1:0]        o_head,
   output logic                         o_vld,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [SKID_ENT_W-1:0] r_ent   [DEPTH];
   logic [SKID_ENT_W-1:0] w_shift [DEPTH];
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_wr_idx;
   logic                  w_pop;

   // Shifted view of the entries after a pop, and the slot a push lands in
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_shift[i] = '0;
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         w_shift[i] = r_ent[i + 1];
      end
      w_pop    = i_pop && (r_cnt != '0);
      w_wr_idx = r_cnt - CNT_W'(w_pop);
   end

   // Entries shift toward the head on pop; unused slots stay zero so an empty head reads 0
   always_ff @(posedge clk_sys or negedge rstn_sys) begin
      if (!rstn_sys) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i] <= '0;
         end
         r_cnt <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_push && (w_wr_idx == CNT_W'(i))) begin
               r_ent[i] <= i_dat;
            end else if (w_pop) begin
               r_ent[i] <= w_shift[i];
            end
         end
         r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(w_pop);
      end
   end

   assign o_head  = r_ent[0];
   assign o_vld   = (r_cnt != '0);
   assign o_count = r_cnt;

endmodule

// File: rtl/switch_frame_fetch.sv
// Pops a descriptor, fetches len bytes from the byte FIFO and streams them with sof/eof framing.
// Latency: first frm_valid 4 cycles after ptr_sfifo_rd; 1 byte/cycle; len+5 cycles per frame.
// Backpressure: byte reads are throttled so skid occupancy plus in-flight reads never exceed SKID_DEPTH.
module switch_frame_fetch
   import switch_frame_fetch_pkg::*;
#(
   parameter int LEN_W      = DEFAULT_LEN_W,
   parameter int SKID_DEPTH = 2
) (
   input  logic                clk_sys,
   input  logic                rstn_sys,
   output logic                ptr_sfifo_rd,
   input  logic [DESC_W-1:0]   ptr_sfifo_dout,
   input  logic                ptr_sfifo_empty,
   output logic                sfifo_rd,
   input  logic [BYTE_W-1:0]   sfifo_dout,
   output logic                frm_valid,
   input  logic                frm_ready,
   output logic [BYTE_W-1:0]   frm_data,
   output logic                frm_sof,
   output logic                frm_eof,
   output logic [SRC_W-1:0]    frm_src,
   output logic [TAG_W-1:0]    frm_tag,
   output logic [LEN_W-1:0]    frm_len,
   output logic [15:0]         frame_cnt,
   output logic [15:0]         drop_cnt
);

   localparam int CNT_W = $clog2(SKID_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   fetch_state_t          r_state;
   logic                  r_arm;
   logic [LEN_W-1:0]      r_rd_cnt;
   logic [LEN_W-1:0]      r_len;
   logic [SRC_W-1:0]      r_src;
   logic [TAG_W-1:0]      r_tag;
   logic                  r_in_flight;
   logic                  r_if_sof;
   logic                  r_if_eof;
   logic                  r_done;
   logic [15:0]           r_frame_cnt;
   logic [15:0]           r_drop_cnt;

   logic [LEN_W-1:0]      w_desc_len;
   logic [SRC_W-1:0]      w_desc_src;
   logic [TAG_W-1:0]      w_desc_tag;
   logic                  w_accept;
   logic [OCC_W-1:0]      w_occ;
   logic                  w_issue;
   logic                  w_ptr_rd;
   skid_ent_t             w_push_ent;
   skid_ent_t             w_head;
   logic [SKID_ENT_W-1:0] w_head_raw;
   logic                  w_skid_vld;
   logic [CNT_W-1:0]      w_skid_cnt;

   assign w_desc_len = LEN_W'(ptr_sfifo_dout[DESC_LEN_LSB +: DESC_LEN_W]);
   assign w_desc_src = ptr_sfifo_dout[DESC_SRC_LSB +: SRC_W];
   assign w_desc_tag = ptr_sfifo_dout[DESC_TAG_LSB +: TAG_W];

   // Read issue: count what will occupy the skid once this cycle's transfer and returning read settle
   always_comb begin
      w_accept = w_skid_vld && frm_ready;
      w_occ    = OCC_W'(w_skid_cnt) + OCC_W'(r_in_flight) - OCC_W'(w_accept);
      w_issue  = (r_state == ST_DATA) && (r_rd_cnt < r_len) && (w_occ < OCC_W'(SKID_DEPTH));
      // r_arm keeps the pop low while reset is held even if the descriptor FIFO is not empty
      w_ptr_rd = r_arm && (r_state == ST_IDLE) && !ptr_sfifo_empty;
   end

   // Fetch FSM with its counters, latched descriptor fields and in-flight read tracking
   always_ff @(posedge clk_sys or negedge rstn_sys) begin
      if (!rstn_sys) begin
         r_state     <= ST_IDLE;
         r_arm       <= 1'b0;
         r_rd_cnt    <= '0;
         r_len       <= '0;
         r_src       <= '0;
         r_tag       <= '0;
         r_in_flight <= 1'b0;
         r_if_sof    <= 1'b0;
         r_if_eof    <= 1'b0;
         r_done      <= 1'b0;
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_arm       <= 1'b1;
         // Framing flags travel with the read so the returning byte is tagged without a second counter
         r_in_flight <= w_issue;
         r_if_sof    <= w_issue && (r_rd_cnt == '0);
         r_if_eof    <= w_issue && (r_rd_cnt == (r_len - LEN_W'(1)));
         case (r_state)
            ST_IDLE: begin
               if (w_ptr_rd) begin
                  r_state <= ST_LATCH;
               end
            end
            ST_LATCH: begin
               r_len    <= w_desc_len;
               r_src    <= w_desc_src;
               r_tag    <= w_desc_tag;
               r_rd_cnt <= '0;
               if (w_desc_len == '0) begin
                  r_drop_cnt <= r_drop_cnt + 16'd1;
                  r_state    <= ST_IDLE;
               end else begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_issue) begin
                  r_rd_cnt <= r_rd_cnt + LEN_W'(1);
                  if (r_rd_cnt == (r_len - LEN_W'(1))) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // The cycle after the eof transfer closes the frame and hands back to IDLE
               if (r_done) begin
                  r_done      <= 1'b0;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  r_state     <= ST_IDLE;
               end else if (w_accept && w_head.eof) begin
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_push_ent = '{sof: r_if_sof, eof: r_if_eof, dat: sfifo_dout};
   assign w_head     = w_head_raw;

   frame_skid_buf #(
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk_sys  (clk_sys),
      .rstn_sys (rstn_sys),
      .i_push   (r_in_flight),
      .i_dat    (w_push_ent),
      .i_pop    (w_accept),
      .o_head   (w_head_raw),
      .o_vld    (w_skid_vld),
      .o_count  (w_skid_cnt)
   );

   assign ptr_sfifo_rd = w_ptr_rd;
   assign sfifo_rd     = w_issue;
   assign frm_valid    = w_skid_vld;
   assign frm_data     = w_head.dat;
   assign frm_sof      = w_head.sof;
   assign frm_eof      = w_head.eof;
   assign frm_src      = r_src;
   assign frm_tag      = r_tag;
   assign frm_len      = r_len;
   assign frame_cnt    = r_frame_cnt;
   assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_switch_frame_fetch.sv
// Directed bench for switch_frame_fetch with behavioural upstream FIFOs and a transfer monitor.
// Latency: n/a.
// Backpressure: frm_ready held high or toggled pseudo-randomly per cycle.
module tb_switch_frame_fetch;

   localparam int LEN_W      = 11;
   localparam int SKID_DEPTH = 2;

   logic              clk_sys = 1'b0;
   logic              rstn_sys = 1'b0;
   logic              ptr_sfifo_rd;
   logic [19:0]       ptr_sfifo_dout;
   logic              ptr_sfifo_empty;
   logic              sfifo_rd;
   logic [7:0]        sfifo_dout;
   logic              frm_valid;
   logic              frm_ready;
   logic [7:0]        frm_data;
   logic              frm_sof;
   logic              frm_eof;
   logic [3:0]        frm_src;
   logic [3:0]        frm_tag;
   logic [LEN_W-1:0]  frm_len;
   logic [15:0]       frame_cnt;
   logic [15:0]       drop_cnt;

   switch_frame_fetch #(
      .LEN_W      (LEN_W),
      .SKID_DEPTH (SKID_DEPTH)
   ) dut (
      .clk_sys         (clk_sys),
      .rstn_sys        (rstn_sys),
      .ptr_sfifo_rd    (ptr_sfifo_rd),
      .ptr_sfifo_dout  (ptr_sfifo_dout),
      .ptr_sfifo_empty (ptr_sfifo_empty),
      .sfifo_rd        (sfifo_rd),
      .sfifo_dout      (sfifo_dout),
      .frm_valid       (frm_valid),
      .frm_ready       (frm_ready),
      .frm_data        (frm_data),
      .frm_sof         (frm_sof),
      .frm_eof         (frm_eof),
      .frm_src         (frm_src),
      .frm_tag         (frm_tag),
      .frm_len         (frm_len),
      .frame_cnt       (frame_cnt),
      .drop_cnt        (drop_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Upstream FIFO contents, expected stream and monitor records
   logic [19:0] desc_q[$];
   logic [7:0]  byte_q[$];
   logic [17:0] exp_q[$];
   logic [17:0] rx_q[$];
   int          ptr_cyc_q[$];
   int          sof_cyc_q[$];
   int          eof_cyc_q[$];
   int          rd_pulses = 0;
   int          skid_max = 0;
   int          hold_err = 0;
   int          cyc = 0;
   int          rdy_mode = 0;
   logic        ptr_pend = 1'b0;
   logic        byte_pend = 1'b0;

   // Upstream FIFOs answer a pop with data one cycle later; frm_ready is refreshed each cycle
   initial begin
      ptr_sfifo_dout  = '0;
      ptr_sfifo_empty = 1'b1;
      sfifo_dout      = '0;
      frm_ready       = 1'b1;
      forever begin
         @(posedge clk_sys);
         cyc++;
         #1;
         if (ptr_pend && desc_q.size() > 0) ptr_sfifo_dout = desc_q.pop_front();
         if (byte_pend && byte_q.size() > 0) sfifo_dout = byte_q.pop_front();
         ptr_pend        = 1'b0;
         byte_pend       = 1'b0;
         ptr_sfifo_empty = (desc_q.size() == 0);
         frm_ready       = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Monitor on the falling edge: pops, transfers, hold stability, skid occupancy
   initial begin
      logic       prev_hold;
      logic [9:0] prev_ent;
      prev_hold = 1'b0;
      prev_ent  = '0;
      forever begin
         @(negedge clk_sys);
         if (!rstn_sys) begin
            prev_hold = 1'b0;
         end else begin
            ptr_pend  = ptr_sfifo_rd;
            byte_pend = sfifo_rd;
            if (ptr_sfifo_rd) ptr_cyc_q.push_back(cyc);
            if (sfifo_rd) rd_pulses++;
            if (int'(dut.w_skid_cnt) > skid_max) skid_max = int'(dut.w_skid_cnt);
            if (prev_hold && !(frm_valid && ({frm_sof, frm_eof, frm_data} == prev_ent))) hold_err++;
            prev_hold = frm_valid && !frm_ready;
            prev_ent  = {frm_sof, frm_eof, frm_data};
            if (frm_valid && frm_ready) begin
               rx_q.push_back({frm_src, frm_tag, frm_sof, frm_eof, frm_data});
               if (frm_sof) sof_cyc_q.push_back(cyc);
               if (frm_eof) eof_cyc_q.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   task automatic push_frame(input int len, input logic [3:0] src, input logic [3:0] tag,
                             input logic [7:0] seed);
      for (int i = 0; i < len; i++) begin
         logic [7:0] b;
         b = seed + 8'(i);
         byte_q.push_back(b);
         exp_q.push_back({src, tag, (i == 0), (i == len - 1), b});
      end
      desc_q.push_back({tag, src, 1'b0, 11'(len)});
   endtask

   task automatic clear_stats();
      exp_q.delete();
      rx_q.delete();
      ptr_cyc_q.delete();
      sof_cyc_q.delete();
      eof_cyc_q.delete();
      rd_pulses = 0;
   endtask

   task automatic wait_frames(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (frame_cnt != 16'(target) && n < budget) begin
         @(posedge clk_sys);
         n++;
      end
      repeat (2) @(posedge clk_sys);
      #2;
      chk({tag, "_frame_cnt"}, frame_cnt, target);
   endtask

   task automatic check_rx(input string tag);
      int bad;
      bad = 0;
      chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         if (rx_q[i] !== exp_q[i]) bad++;
      end
      chk({tag, "_content"}, bad, 0);
   endtask

   initial begin
      int n;

      // Reset: a descriptor is already waiting, yet nothing may be popped or driven
      clear_stats();
      push_frame(64, 4'b0001, 4'h3, 8'h00);
      repeat (3) @(posedge clk_sys);
      #2;
      chk("rst_ctl", {frm_valid, frm_sof, frm_eof, sfifo_rd, ptr_sfifo_rd}, 0);
      chk("rst_dat", {frm_src, frm_tag, frm_data, frm_len}, 0);
      chk("rst_cnt", {frame_cnt, drop_cnt}, 0);
      @(negedge clk_sys);
      rstn_sys = 1'b1;

      // A: len=64, bytes 0..63, ready high
      wait_frames(1, 2000, "A");
      check_rx("A");
      chk("A_latency", sof_cyc_q[0] - ptr_cyc_q[0], 4);
      chk("A_contig", eof_cyc_q[0] - sof_cyc_q[0], 63);
      chk("A_rd_pulses", rd_pulses, 64);
      chk("A_len", frm_len, 64);

      // B: single-byte frame carries sof and eof together
      clear_stats();
      push_frame(1, 4'b0100, 4'hA, 8'h5A);
      wait_frames(2, 500, "B");
      check_rx("B");
      chk("B_src", frm_src, 4'b0100);
      chk("B_tag", frm_tag, 4'hA);
      chk("B_latency", sof_cyc_q[0] - ptr_cyc_q[0], 4);

      // C: zero-length descriptor is dropped without any byte read
      clear_stats();
      push_frame(0, 4'b0010, 4'h1, 8'h00);
      push_frame(3, 4'b0010, 4'h7, 8'h10);
      wait_frames(3, 500, "C");
      chk("C_drop_cnt", drop_cnt, 1);
      check_rx("C");
      chk("C_rd_pulses", rd_pulses, 3);
      chk("C_len", frm_len, 3);

      // D: len=100 under random backpressure
      clear_stats();
      rdy_mode = 1;
      push_frame(100, 4'b1000, 4'h1, 8'h80);
      wait_frames(4, 3000, "D");
      rdy_mode = 0;
      check_rx("D");
      chk("D_rd_pulses", rd_pulses, 100);
      chk("D_skid_over", (skid_max > SKID_DEPTH), 0);
      chk("D_hold_err", hold_err, 0);

      // E: three back-to-back frames separated by five idle cycles
      clear_stats();
      push_frame(60, 4'b0001, 4'h4, 8'h20);
      push_frame(1518, 4'b0010, 4'h5, 8'h33);
      push_frame(2047, 4'b0100, 4'h6, 8'h47);
      wait_frames(7, 8000, "E");
      check_rx("E");
      chk("E_gap0", sof_cyc_q[1] - eof_cyc_q[0] - 1, 5);
      chk("E_gap1", sof_cyc_q[2] - eof_cyc_q[1] - 1, 5);
      chk("E_period", ptr_cyc_q[1] - ptr_cyc_q[0], 65);
      chk("E_rd_pulses", rd_pulses, 3625);
      chk("E_len", frm_len, 2047);

      // F: reset at byte 30 of a 64-byte frame, then a clean frame
      clear_stats();
      push_frame(64, 4'b0010, 4'h3, 8'h00);
      n = 0;
      while (rx_q.size() < 30 && n < 1000) begin
         @(posedge clk_sys);
         n++;
      end
      chk("F_reached_30", rx_q.size(), 30);
      #2;
      rstn_sys = 1'b0;
      #1;
      chk("F_rst_ctl", {frm_valid, frm_sof, frm_eof, sfifo_rd, ptr_sfifo_rd}, 0);
      chk("F_rst_dat", {frm_src, frm_tag, frm_data, frm_len}, 0);
      chk("F_rst_cnt", {frame_cnt, drop_cnt}, 0);
      repeat (2) @(posedge clk_sys);
      desc_q.delete();
      byte_q.delete();
      clear_stats();
      push_frame(5, 4'b0001, 4'h9, 8'hC0);
      @(negedge clk_sys);
      rstn_sys = 1'b1;
      wait_frames(1, 500, "F");
      check_rx("F");
      chk("F_latency", sof_cyc_q[0] - ptr_cyc_q[0], 4);
      chk("F_hold_err", hold_err, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
